icache_refill_ctrl: RTL and testbench

- Write-side controller for the 4-way, 64-set, 64-byte-line instruction-cache tag/valid and data arrays.
- On a lookup miss: selects a victim way, issues a line read to the memory interface, streams 16 returned words into the data array, then commits the new tag with valid set.
- Also runs the IBAR invalidate sweep, clearing valid bits in all 64 sets of all ways.
- Its outputs directly drive the tag/valid array write port (we, w_addr, ibar_clear, ibar_tagv_addr).

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_victim_sel.sv | 83 ++++++++
 rtl/icache_refill_ctrl.sv | 134 +++++++++++++
 tb/tb_icache_refill_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache refill path.
package icache_pkg;

  localparam int unsigned WAYS       = 4;
  localparam int unsigned SETS       = 64;
  localparam int unsigned LINE_WORDS = 16;

  localparam int unsigned IDX_LSB = 6;
  localparam int unsigned IDX_MSB = 11;
  localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned OFF_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_REFILL = 3'd2,
    ST_TAGWR  = 3'd3,
    ST_DONE   = 3'd4,
    ST_IBAR   = 3'd5
  } state_t;

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise a 4-bit LFSR,
// or a per-set tree pseudo-LRU when ICACHE_PLRU_EN is defined.
module icache_victim_sel
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  fill_way,
  input  logic [IDX_W-1:0] fill_index,
  output logic [WAYS-1:0]  victim
);

  logic [WAYS-1:0] invalid_pick;
  logic [WAYS-1:0] full_pick;

  always_comb begin
    casez (way_valid)
      4'b???0: invalid_pick = 4'b0001;
      4'b??01: invalid_pick = 4'b0010;
      4'b?011: invalid_pick = 4'b0100;
      4'b0111: invalid_pick = 4'b1000;
      default: invalid_pick = 4'b0000;
    endcase
  end

  assign victim = (|invalid_pick) ? invalid_pick : full_pick;

`ifdef ICACHE_PLRU_EN
  logic [2:0] plru [SETS];
  logic [2:0] tree;

  // Bit 0 picks the half, bits 1/2 pick within the low/high pair;
  // an access steers each traversed bit toward the other side.
  function automatic logic [2:0] touch(input logic [2:0] t, input logic [WAYS-1:0] way);
    logic [2:0] r;
    r = t;
    if (way[0] | way[1]) begin
      r[0] = 1'b1;
      r[1] = way[0];
    end else begin
      r[0] = 1'b0;
      r[2] = way[2];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      if (|hit)      plru[lookup_index] <= touch(plru[lookup_index], hit);
      if (|fill_way) plru[fill_index]   <= touch(plru[fill_index], fill_way);
    end
  end

  always_comb begin
    tree      = plru[lookup_index];
    full_pick = '0;
    if (tree[0]) full_pick[tree[2] ? 3 : 2] = 1'b1;
    else         full_pick[tree[1] ? 1 : 0] = 1'b1;
  end
`else
  logic [3:0] lfsr;
  logic       unused_plru_inputs;

  assign unused_plru_inputs = ^{hit, fill_way, fill_index, lookup_index};

  // x^4 + x^3 + 1, maximal length, never reaches all-zero from 4'b0001.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 4'b0001;
    else     lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  always_comb begin
    full_pick            = '0;
    full_pick[lfsr[1:0]] = 1'b1;
  end
`endif

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill / IBAR sweep controller driving the tag/valid and
// data array write ports. Optional tree-PLRU victim via ICACHE_PLRU_EN.
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  input  logic [3:0]  way_valid,
  input  logic [3:0]  hit,
  output logic        miss_done,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic [31:0] ret_data,
  output logic [3:0]  data_we,
  output logic [5:0]  data_index,
  output logic [3:0]  data_offset,
  output logic [31:0] data_wdata,
  output logic [3:0]  we,
  output logic [31:0] w_addr,
  input  logic        ibar_req,
  output logic        ibar_clear,
  output logic [5:0]  ibar_tagv_addr,
  output logic        ibar_done,
  output logic        busy
);

  state_t           state, state_nx;
  logic [31:0]      addr_q;
  logic [WAYS-1:0]  victim, victim_q, fill_way;
  logic [OFF_W-1:0] cnt;
  logic [IDX_W-1:0] sweep;
  logic             ibar_pend, ibar_done_q;
  logic             latch_miss, beat, last_beat, sweep_last;

  assign fill_way = (state == ST_TAGWR) ? victim_q : '0;

  icache_victim_sel u_victim_sel (
    .clk          (clk),
    .rst          (rst),
    .way_valid    (way_valid),
    .lookup_index (miss_addr[IDX_MSB:IDX_LSB]),
    .hit          (hit),
    .fill_way     (fill_way),
    .fill_index   (addr_q[IDX_MSB:IDX_LSB]),
    .victim       (victim)
  );

  assign beat       = (state == ST_REFILL) && ret_valid;
  assign last_beat  = beat && (cnt == OFF_W'(LINE_WORDS - 1));
  assign sweep_last = (state == ST_IBAR) && (sweep == IDX_W'(SETS - 1));

  always_comb begin
    state_nx   = state;
    latch_miss = 1'b0;
    rd_req     = 1'b0;
    data_we    = '0;
    we         = '0;
    miss_done  = 1'b0;
    ibar_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ibar_req || ibar_pend) begin
          state_nx = ST_IBAR;
        end else if (miss_valid) begin
          latch_miss = 1'b1;
          state_nx   = ST_REQ;
        end
      end
      ST_REQ: begin
        rd_req = 1'b1;
        if (rd_rdy) state_nx = ST_REFILL;
      end
      ST_REFILL: begin
        if (beat)      data_we  = victim_q;
        if (last_beat) state_nx = ST_TAGWR;
      end
      ST_TAGWR: begin
        we       = victim_q;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        miss_done = 1'b1;
        state_nx  = (ibar_pend || ibar_req) ? ST_IBAR : ST_IDLE;
      end
      ST_IBAR: begin
        ibar_clear = 1'b1;
        we         = '1;
        if (sweep_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      victim_q    <= '0;
      cnt         <= '0;
      sweep       <= '0;
      ibar_pend   <= 1'b0;
      ibar_done_q <= 1'b0;
    end else begin
      state       <= state_nx;
      ibar_done_q <= sweep_last;
      sweep       <= (state == ST_IBAR) ? sweep + 1'b1 : '0;
      if (latch_miss) begin
        addr_q   <= miss_addr;
        victim_q <= victim;
        cnt      <= '0;
      end
      if (beat) cnt <= cnt + 1'b1;
      // A request seen outside IDLE/IBAR is held until the sweep starts.
      if (state == ST_IBAR)
        ibar_pend <= 1'b0;
      else if (ibar_req && state != ST_IDLE)
        ibar_pend <= 1'b1;
    end
  end

  assign rd_addr        = {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
  assign w_addr         = addr_q;
  assign data_index     = addr_q[IDX_MSB:IDX_LSB];
  assign data_offset    = cnt;
  assign data_wdata     = beat ? ret_data : '0;
  assign ibar_tagv_addr = ibar_clear ? sweep : '0;
  assign ibar_done      = ibar_done_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: refills, backpressure, IBAR ordering, async reset.
`timescale 1ns/1ps
module tb_icache_refill_ctrl;

  logic        clk = 1'b0, rst = 1'b1;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic [3:0]  way_valid = '0, hit = '0;
  logic        miss_done, rd_req, rd_rdy = 1'b0, ret_valid = 1'b0;
  logic [31:0] rd_addr, ret_data = '0, data_wdata, w_addr;
  logic [3:0]  data_we, data_offset, we;
  logic [5:0]  data_index, ibar_tagv_addr;
  logic        ibar_req = 1'b0, ibar_clear, ibar_done, busy;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .way_valid(way_valid), .hit(hit), .miss_done(miss_done), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data),
    .data_we(data_we), .data_index(data_index), .data_offset(data_offset),
    .data_wdata(data_wdata), .we(we), .w_addr(w_addr), .ibar_req(ibar_req),
    .ibar_clear(ibar_clear), .ibar_tagv_addr(ibar_tagv_addr), .ibar_done(ibar_done),
    .busy(busy)
  );

  int unsigned checks = 0, errors = 0;

  typedef struct packed {
    logic [3:0]  way;
    logic [3:0]  off;
    logic [5:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_got, mon_exp;
  logic [3:0] lfsr_m;

  // Reference x^4+x^3+1 sequence starting from 0001 after reset.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 4'b0001;
    else     lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every data-array write must match the next queued beat.
  always @(negedge clk) begin
    if (data_we !== 4'b0000) begin
      mon_got = {data_we, data_offset, data_index, data_wdata};
      if (exp_q.size() == 0) begin
        check("unexpected_beat", mon_got, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", mon_got, mon_exp);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_rd_req"}, rd_req, 0);
    check({p, "_data_we"}, data_we, 0);
    check({p, "_we"}, we, 0);
    check({p, "_miss_done"}, miss_done, 0);
    check({p, "_ibar_clear"}, ibar_clear, 0);
    check({p, "_ibar_done"}, ibar_done, 0);
    check({p, "_rd_addr"}, rd_addr, 0);
    check({p, "_w_addr"}, w_addr, 0);
    check({p, "_data_wdata"}, data_wdata, 0);
    check({p, "_data_offset"}, data_offset, 0);
    check({p, "_ibar_addr"}, ibar_tagv_addr, 0);
  endtask

  // Entered at posedge+1 with the sweep's first cycle; leaves at the negedge of the ibar_done cycle.
  task automatic sweep_check();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("ibar_clear", ibar_clear, 1);
      check("ibar_addr", ibar_tagv_addr, i);
      check("ibar_we", we, 4'hF);
      check("ibar_no_req", rd_req, 0);
      check("ibar_done_early", ibar_done, 0);
      next();
    end
    @(negedge clk);
    check("ibar_done", ibar_done, 1);
    check("ibar_clear_off", ibar_clear, 0);
    check("ibar_we_off", we, 0);
  endtask

  task automatic do_refill(input logic [31:0] a, input logic [3:0] wv, input int bp,
                           input int gap, input bit ibar_first, input int ibar_beat);
    logic [3:0] vic;
    miss_valid = 1'b1;
    miss_addr  = a;
    way_valid  = wv;
    ibar_req   = ibar_first;
    @(negedge clk);
    check("idle_busy", busy, 0);
    if (ibar_first) begin
      next();
      ibar_req = 1'b0;
      sweep_check();
    end
    vic = '0;
    if (wv == 4'hF) begin
      vic[lfsr_m[1:0]] = 1'b1;
    end else begin
      for (int w = 3; w >= 0; w--)
        if (!wv[w]) begin
          vic    = '0;
          vic[w] = 1'b1;
        end
    end
    next();
    for (int i = 0; i < bp; i++) begin
      rd_rdy = 1'b0;
      @(negedge clk);
      check("req_held", rd_req, 1);
      check("rd_addr_hold", rd_addr, {a[31:6], 6'b0});
      next();
    end
    rd_rdy = 1'b1;
    @(negedge clk);
    check("rd_req", rd_req, 1);
    check("rd_addr", rd_addr, {a[31:6], 6'b0});
    next();
    rd_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        ret_valid = 1'b0;
        next();
      end
      ret_valid = 1'b1;
      ret_data  = $urandom;
      ibar_req  = (i == ibar_beat);
      exp_q.push_back({vic, 4'(i), a[11:6], ret_data});
      @(negedge clk);
      check("refill_no_tagwe", we, 0);
      next();
      ret_valid = 1'b0;
      ibar_req  = 1'b0;
    end
    @(negedge clk);
    check("beats_done", exp_q.size(), 0);
    check("tagwr_we", we, vic);
    check("tagwr_onehot", $countones(we), 1);
    check("w_addr", w_addr, a);
    check("tagwr_no_done", miss_done, 0);
    next();
    @(negedge clk);
    check("miss_done", miss_done, 1);
    check("done_we", we, 0);
    next();
    miss_valid = 1'b0;
    if (ibar_beat >= 0) begin
      sweep_check();
      next();
    end
    @(negedge clk);
    check("after_busy", busy, 0);
    check("miss_done_pulse", miss_done, 0);
    check("ibar_done_pulse", ibar_done, 0);
    next();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("in_reset");
    next();
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");
    next();

    // Cold miss into way0 at index 1.
    do_refill(32'h1C00_0040, 4'b0000, 0, 0, 1'b0, -1);
    // Full set: LFSR victim, request backpressure and gaps between beats.
    do_refill(32'h8000_0A80, 4'b1111, 5, 2, 1'b0, -1);
    // IBAR raised at beat 7 runs after the refill completes.
    do_refill(32'h0040_07C4, 4'b0111, 0, 1, 1'b0, 7);
    // IBAR and miss together in IDLE: sweep first.
    do_refill(32'h1234_5678, 4'b1011, 1, 0, 1'b1, -1);

    // Async reset in the middle of beat 10.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0FC0;
    way_valid  = 4'b1110;
    @(negedge clk);
    next();
    rd_rdy = 1'b1;
    @(negedge clk);
    next();
    rd_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ret_valid = 1'b1;
      ret_data  = $urandom;
      exp_q.push_back({4'b0001, 4'(i), 6'd63, ret_data});
      @(negedge clk);
      next();
    end
    ret_data = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    miss_valid = 1'b0;
    next();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_beat_busy", busy, 0);
      next();
    end
    ret_valid = 1'b0;
    check("reset_beats_consumed", exp_q.size(), 0);
    do_refill(32'h2000_1234, 4'b0001, 2, 1, 1'b0, -1);

    repeat (2) next();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
